cmd_cfg: RTL and testbench
==========================

Name: cmd_cfg

Overview:
- Command processor directly downstream of UART_comm in the quadcopter.
- Consumes cmd_rdy/cmd/data and clears cmd_rdy.
- Updates flight setpoints, controls motor-off and inertial calibration, and returns one response byte per command through UART_comm's send_resp/resp/resp_sent handshake.

Parameters:
FAST_SIM, 1, 1 = 9-bit motor-ramp timer for simulation; 0 = 26-bit timer (~1.34 s at 50 MHz).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_rdy  input  1  new command valid (from UART_comm)
cmd  input  8  command opcode
data  input  16  command payload
clr_cmd_rdy  output  1  one-cycle pulse; command consumed
resp  output  8  response byte to UART_comm
send_resp  output  1  one-cycle pulse; start response transmission
resp_sent  input  1  response transmission complete
batt  input  8  battery level
cal_done  input  1  inertial calibration complete
d_ptch  output  16  signed pitch setpoint
d_roll  output  16  signed roll setpoint
d_yaw  output  16  signed yaw setpoint
thrst  output  9  unsigned thrust setpoint
strt_cal  output  1  one-cycle pulse; start inertial calibration
inertial_cal  output  1  high during calibration
motors_off  output  1  motors disabled

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: d_ptch/d_roll/d_yaw = 0, thrst = 0, motors_off = 1, resp = 0, all pulse outputs and inertial_cal = 0, state = IDLE, ramp timer = 0.
- Opcodes: SET_PTCH 02, SET_ROLL 03, SET_YAW 04, GET_BATT 05, SET_THRST 06, CALIBRATE 07, EMER_LAND 08, MTRS_OFF 09.
- Response codes: ACK = A5, NACK = EE.
- IDLE, cmd_rdy = 1: pulse clr_cmd_rdy for one cycle, decode cmd in that same cycle.
  - SET_PTCH/ROLL/YAW: load the matching register with data. SET_THRST: thrst <= data[8:0]. Then resp = A5, pulse send_resp, go to WAIT_TX.
  - GET_BATT: resp = batt sampled that cycle, pulse send_resp, go to WAIT_TX.
  - EMER_LAND: zero all four setpoints, ACK, go to WAIT_TX.
  - MTRS_OFF: motors_off <= 1, ACK, go to WAIT_TX.
  - CALIBRATE: motors_off <= 0, clear ramp timer, go to RAMP; no response yet.
  - Any other opcode: resp = EE, pulse send_resp, go to WAIT_TX. No setpoint change.
- RAMP: timer increments each clock. When all ones: pulse strt_cal, set inertial_cal, go to CAL.
- CAL: hold inertial_cal = 1. cal_done = 1 → clear inertial_cal, resp = A5, pulse send_resp, go to WAIT_TX. cal_done is ignored outside CAL.
- WAIT_TX: stay until resp_sent = 1, then go to IDLE. The earliest next-command acceptance is the cycle after resp_sent.
- cmd_rdy arriving outside IDLE is not cleared; it is serviced on return to IDLE.
- Setpoint registers hold their value between commands. No arithmetic beyond truncation of data to 9 bits for thrst.
- Reset in any state (including RAMP/CAL) forces all reset values immediately; an in-progress calibration is abandoned and motors_off returns to 1.

Optional Feature:
- Macro CMD_CFG_WDOG_EN.
- Defined: adds a link-loss watchdog counter, 26 bits (10 bits when FAST_SIM = 1). It clears on every accepted command and increments otherwise. When it reaches all ones while motors_off = 0 and state = IDLE, all four setpoints are zeroed, as for EMER_LAND but with no response sent. The counter then saturates until the next command.
- Undefined: no counter; setpoints change only on commands.

Decomposition:
- Package cmd_cfg_pkg holds:
  - cmd_t enum for the eight opcodes;
  - localparams ACK = 8'hA5 and NACK = 8'hEE;
  - state_t enum {IDLE, RAMP, CAL, WAIT_TX}.
- One sub-module: cmd_ramp_timer, a FAST_SIM-sized counter with clear input and full output. Reused by the watchdog if desired.

Test Plan:
- SET_PTCH, data 0xFF38 → d_ptch = 0xFF38 (-200), clr_cmd_rdy pulses once, resp = A5 with send_resp, IDLE only after resp_sent.
- SET_THRST, data 0x01FF then GET_BATT with batt = 0xC4 → thrst = 0x1FF, second response = C4.
- CALIBRATE, FAST_SIM = 1 → motors_off falls; strt_cal pulses exactly 511 clocks later; inertial_cal stays high until cal_done; then A5.
- Setpoints nonzero, then EMER_LAND → all four = 0, A5. Then MTRS_OFF → motors_off = 1.
- Opcode 0x3F → resp = EE, no output change. A second cmd_rdy asserted during WAIT_TX is serviced only after resp_sent.
- rst_n deasserted during CAL → outputs at reset values, motors_off = 1. With CMD_CFG_WDOG_EN, FAST_SIM = 1: after CALIBRATE completes, 1023 idle clocks → setpoints zeroed, no send_resp.

Source files
------------

// File: rtl/cmd_cfg_pkg.sv
// Shared opcodes, response codes, FSM states and sizing helpers for the cmd_cfg command processor.
package cmd_cfg_pkg;

    typedef enum logic [7:0] {
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        GET_BATT  = 8'h05,
        SET_THRST = 8'h06,
        CALIBRATE = 8'h07,
        EMER_LAND = 8'h08,
        MTRS_OFF  = 8'h09
    } cmd_t;

    localparam logic [7:0] ACK  = 8'hA5;
    localparam logic [7:0] NACK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        CAL     = 2'd2,
        WAIT_TX = 2'd3
    } state_t;

    function automatic int ramp_width(input int fast_sim);
        if (fast_sim != 32'sd0) begin
            return 32'sd9;
        end else begin
            return 32'sd26;
        end
    endfunction

    function automatic int wdog_width(input int fast_sim);
        if (fast_sim != 32'sd0) begin
            return 32'sd10;
        end else begin
            return 32'sd26;
        end
    endfunction

    // Immediate response byte for an opcode; CALIBRATE acknowledges later, after cal_done.
    function automatic logic [7:0] resp_code(input logic [7:0] op, input logic [7:0] batt_lvl);
        logic [7:0] code;
        case (op)
            SET_PTCH, SET_ROLL, SET_YAW, SET_THRST,
            CALIBRATE, EMER_LAND, MTRS_OFF: code = ACK;
            GET_BATT:                       code = batt_lvl;
            default:                        code = NACK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cmd_cfg_if.sv
// Command/response handshake between UART_comm (master) and cmd_cfg (slave).
interface cmd_cfg_if;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    modport master (
        output cmd_rdy, cmd, data, resp_sent,
        input  clr_cmd_rdy, resp, send_resp
    );

    modport slave (
        input  cmd_rdy, cmd, data, resp_sent,
        output clr_cmd_rdy, resp, send_resp
    );
endinterface

// File: rtl/cmd_ramp_timer.sv
// Free-running up-counter with synchronous clear; full is high while the count is all ones.
module cmd_ramp_timer #(
    parameter int WIDTH = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic full
);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_r;

    // Clear wins over count; the count wraps unless the caller gates en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign full = (cnt_r == ALL_ONES);
endmodule

// File: rtl/cmd_cfg.sv
// cmd_cfg: command processor behind UART_comm; owns flight setpoints, motor-off, calibration and responses.
// Defining CMD_CFG_WDOG_EN adds a link-loss watchdog that zeroes setpoints when commands stop arriving.
module cmd_cfg
    import cmd_cfg_pkg::*;
#(
    parameter int FAST_SIM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cmd_cfg_if.slave           bus,
    input  logic [7:0]         batt,
    input  logic               cal_done,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    output logic               motors_off
);

    state_t             state_r;
    logic signed [15:0] d_ptch_r;
    logic signed [15:0] d_roll_r;
    logic signed [15:0] d_yaw_r;
    logic [8:0]         thrst_r;
    logic [7:0]         resp_r;
    logic               clr_cmd_rdy_r;
    logic               send_resp_r;
    logic               strt_cal_r;
    logic               inertial_cal_r;
    logic               motors_off_r;

    logic accept_s;
    logic cal_accept_s;
    logic ramp_clr_s;
    logic ramp_full_s;
    logic wd_trip_s;

    assign accept_s     = (state_r == IDLE) & bus.cmd_rdy;
    assign cal_accept_s = accept_s & (bus.cmd == CALIBRATE);

    // The ramp timer sits at zero outside RAMP and takes its first step on the accepting edge,
    // so strt_cal rises exactly 2^W-1 clocks after motors_off falls.
    assign ramp_clr_s = (state_r != RAMP) & ~cal_accept_s;

    cmd_ramp_timer #(
        .WIDTH (ramp_width(FAST_SIM))
    ) u_ramp (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ramp_clr_s),
        .en    (1'b1),
        .full  (ramp_full_s)
    );

`ifdef CMD_CFG_WDOG_EN
    logic wd_full_s;

    cmd_ramp_timer #(
        .WIDTH (wdog_width(FAST_SIM))
    ) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_s),
        .en    (~wd_full_s),
        .full  (wd_full_s)
    );

    assign wd_trip_s = wd_full_s & ~motors_off_r & (state_r == IDLE);
`else
    assign wd_trip_s = 1'b0;
`endif

    // Command FSM: decode, setpoint update, response handshake and calibration sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            d_ptch_r       <= 16'sd0;
            d_roll_r       <= 16'sd0;
            d_yaw_r        <= 16'sd0;
            thrst_r        <= 9'd0;
            resp_r         <= 8'h00;
            clr_cmd_rdy_r  <= 1'b0;
            send_resp_r    <= 1'b0;
            strt_cal_r     <= 1'b0;
            inertial_cal_r <= 1'b0;
            motors_off_r   <= 1'b1;
        end else begin
            clr_cmd_rdy_r <= 1'b0;
            send_resp_r   <= 1'b0;
            strt_cal_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.cmd_rdy) begin
                        clr_cmd_rdy_r <= 1'b1;
                        case (bus.cmd)
                            SET_PTCH:  d_ptch_r <= bus.data;
                            SET_ROLL:  d_roll_r <= bus.data;
                            SET_YAW:   d_yaw_r  <= bus.data;
                            SET_THRST: thrst_r  <= bus.data[8:0];
                            EMER_LAND: begin
                                d_ptch_r <= 16'sd0;
                                d_roll_r <= 16'sd0;
                                d_yaw_r  <= 16'sd0;
                                thrst_r  <= 9'd0;
                            end
                            MTRS_OFF:  motors_off_r <= 1'b1;
                            CALIBRATE: motors_off_r <= 1'b0;
                            default:   d_ptch_r <= d_ptch_r;
                        endcase
                        if (bus.cmd == CALIBRATE) begin
                            state_r <= RAMP;
                        end else begin
                            resp_r      <= resp_code(bus.cmd, batt);
                            send_resp_r <= 1'b1;
                            state_r     <= WAIT_TX;
                        end
                    end else if (wd_trip_s) begin
                        d_ptch_r <= 16'sd0;
                        d_roll_r <= 16'sd0;
                        d_yaw_r  <= 16'sd0;
                        thrst_r  <= 9'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RAMP: begin
                    if (ramp_full_s) begin
                        strt_cal_r     <= 1'b1;
                        inertial_cal_r <= 1'b1;
                        state_r        <= CAL;
                    end else begin
                        state_r <= RAMP;
                    end
                end
                CAL: begin
                    if (cal_done) begin
                        inertial_cal_r <= 1'b0;
                        resp_r         <= ACK;
                        send_resp_r    <= 1'b1;
                        state_r        <= WAIT_TX;
                    end else begin
                        state_r <= CAL;
                    end
                end
                WAIT_TX: begin
                    if (bus.resp_sent) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_TX;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.clr_cmd_rdy = clr_cmd_rdy_r;
    assign bus.resp        = resp_r;
    assign bus.send_resp   = send_resp_r;
    assign d_ptch          = d_ptch_r;
    assign d_roll          = d_roll_r;
    assign d_yaw           = d_yaw_r;
    assign thrst           = thrst_r;
    assign strt_cal        = strt_cal_r;
    assign inertial_cal    = inertial_cal_r;
    assign motors_off      = motors_off_r;

endmodule

// File: tb/tb_cmd_cfg.sv
// Directed scoreboard bench for cmd_cfg (FAST_SIM = 1); watchdog checks are built when CMD_CFG_WDOG_EN is defined.
module tb_cmd_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  batt;
    logic        cal_done;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        motors_off;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    cmd_cfg_if bus();

    cmd_cfg #(.FAST_SIM(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .batt         (batt),
        .cal_done     (cal_done),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .motors_off   (motors_off)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, observed running, required done");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " d_ptch"},       32'(d_ptch),          32'h0);
        check({tag, " d_roll"},       32'(d_roll),          32'h0);
        check({tag, " d_yaw"},        32'(d_yaw),           32'h0);
        check({tag, " thrst"},        32'(thrst),           32'h0);
        check({tag, " motors_off"},   32'(motors_off),      32'h1);
        check({tag, " resp"},         32'(bus.resp),        32'h0);
        check({tag, " send_resp"},    32'(bus.send_resp),   32'h0);
        check({tag, " clr_cmd_rdy"},  32'(bus.clr_cmd_rdy), 32'h0);
        check({tag, " strt_cal"},     32'(strt_cal),        32'h0);
        check({tag, " inertial_cal"}, 32'(inertial_cal),    32'h0);
    endtask

    task automatic start_cmd(input logic [7:0] op, input logic [15:0] payload,
                             input logic [7:0] exp_resp, input bit has_resp);
        bus.cmd     = op;
        bus.data    = payload;
        bus.cmd_rdy = 1'b1;
        if (has_resp) exp_q.push_back(exp_resp);
    endtask

    // UART_comm side: drop cmd_rdy as soon as the consume pulse is seen.
    task automatic wait_accept(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.clr_cmd_rdy) seen = 1'b1;
        end
        bus.cmd_rdy = 1'b0;
        check({tag, " accepted"}, 32'(seen), 32'h1);
    endtask

    task automatic get_resp(input string tag);
        bit seen;
        seen = bus.send_resp;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.send_resp) seen = 1'b1;
        end
        check({tag, " send_resp"}, 32'(seen), 32'h1);
        if (seen) begin
            if (exp_q.size() == 0) check({tag, " scoreboard_entry"}, 32'(exp_q.size()), 32'h1);
            else check({tag, " resp"}, 32'(bus.resp), 32'(exp_q.pop_front()));
        end
        @(negedge clk);
        check({tag, " single_pulse"}, {30'd0, bus.send_resp, bus.clr_cmd_rdy}, 32'h0);
    endtask

    task automatic tx_done();
        repeat (2) @(negedge clk);
        bus.resp_sent = 1'b1;
        @(negedge clk);
        bus.resp_sent = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [15:0] payload,
                          input logic [7:0] exp_resp);
        start_cmd(op, payload, exp_resp, 1'b1);
        wait_accept(tag);
        get_resp(tag);
        tx_done();
    endtask

    initial begin
        int cnt;
        int cycles;
        bit found;

        rst_n         = 1'b0;
        batt          = 8'h00;
        cal_done      = 1'b0;
        bus.cmd_rdy   = 1'b0;
        bus.cmd       = 8'h00;
        bus.data      = 16'h0000;
        bus.resp_sent = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Pitch, with a roll command queued while the pitch response is outstanding.
        start_cmd(8'h02, 16'hFF38, 8'hA5, 1'b1);
        wait_accept("ptch");
        check("ptch value", 32'(d_ptch), 32'hFF38);
        get_resp("ptch");
        start_cmd(8'h03, 16'h1234, 8'hA5, 1'b1);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.clr_cmd_rdy) cnt++;
        end
        check("no accept in WAIT_TX", 32'(cnt), 32'h0);
        check("roll untouched in WAIT_TX", 32'(d_roll), 32'h0);
        bus.resp_sent = 1'b1;
        @(negedge clk);
        bus.resp_sent = 1'b0;
        check("no accept on resp_sent cycle", 32'(bus.clr_cmd_rdy), 32'h0);
        wait_accept("roll");
        check("roll value", 32'(d_roll), 32'h1234);
        get_resp("roll");
        tx_done();

        do_cmd("yaw", 8'h04, 16'h8000, 8'hA5);
        check("yaw value", 32'(d_yaw), 32'h8000);
        do_cmd("thrst", 8'h06, 16'h01FF, 8'hA5);
        check("thrst value", 32'(thrst), 32'h1FF);

        batt = 8'hC4;
        do_cmd("batt", 8'h05, 16'h0000, 8'hC4);
        batt = 8'h37;
        do_cmd("batt2", 8'h05, 16'hFFFF, 8'h37);
        check("thrst after batt", 32'(thrst), 32'h1FF);

        do_cmd("bad3F", 8'h3F, 16'h5555, 8'hEE);
        check("bad3F ptch", 32'(d_ptch), 32'hFF38);
        check("bad3F roll", 32'(d_roll), 32'h1234);
        check("bad3F yaw", 32'(d_yaw), 32'h8000);
        check("bad3F thrst", 32'(thrst), 32'h1FF);
        check("bad3F motors_off", 32'(motors_off), 32'h1);
        do_cmd("bad0A", 8'h0A, 16'h0000, 8'hEE);
        do_cmd("bad01", 8'h01, 16'h7777, 8'hEE);
        check("bad01 ptch", 32'(d_ptch), 32'hFF38);

        do_cmd("thrst_trunc", 8'h06, 16'hFE05, 8'hA5);
        check("thrst truncated", 32'(thrst), 32'h005);

        // cal_done outside CAL must do nothing.
        cal_done = 1'b1;
        cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.send_resp) cnt++;
        end
        cal_done = 1'b0;
        check("cal_done ignored resp", 32'(cnt), 32'h0);
        check("cal_done ignored ical", 32'(inertial_cal), 32'h0);

        // Calibration: ramp length, inertial_cal window, deferred ACK.
        start_cmd(8'h07, 16'h0000, 8'hA5, 1'b1);
        wait_accept("cal");
        check("cal motors_off", 32'(motors_off), 32'h0);
        check("cal no early resp", 32'(bus.send_resp), 32'h0);
        check("cal ical in ramp", 32'(inertial_cal), 32'h0);
        cycles = 0;
        found  = 1'b0;
        for (int i = 1; i <= 600 && !found; i++) begin
            @(negedge clk);
            cycles = i;
            if (strt_cal) found = 1'b1;
        end
        check("strt_cal delay", 32'(cycles), 32'd511);
        check("ical set", 32'(inertial_cal), 32'h1);
        @(negedge clk);
        check("strt_cal one cycle", 32'(strt_cal), 32'h0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.send_resp) cnt++;
        end
        check("cal no resp before done", 32'(cnt), 32'h0);
        check("ical held", 32'(inertial_cal), 32'h1);
        cal_done = 1'b1;
        @(negedge clk);
        cal_done = 1'b0;
        check("ical cleared", 32'(inertial_cal), 32'h0);
        get_resp("cal");
        tx_done();

`ifdef CMD_CFG_WDOG_EN
        check("wdog not yet", 32'(d_ptch), 32'hFF38);
        cnt   = 0;
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            @(negedge clk);
            if (bus.send_resp) cnt++;
            if (d_ptch == 16'h0000) found = 1'b1;
        end
        check("wdog ptch zeroed", 32'(found), 32'h1);
        check("wdog roll", 32'(d_roll), 32'h0);
        check("wdog yaw", 32'(d_yaw), 32'h0);
        check("wdog thrst", 32'(thrst), 32'h0);
        check("wdog silent", 32'(cnt), 32'h0);
        check("wdog motors_off", 32'(motors_off), 32'h0);
        do_cmd("reload_ptch", 8'h02, 16'h0100, 8'hA5);
        do_cmd("reload_roll", 8'h03, 16'h0200, 8'hA5);
        do_cmd("reload_yaw", 8'h04, 16'h0300, 8'hA5);
        do_cmd("reload_thrst", 8'h06, 16'h0044, 8'hA5);
        check("reload ptch", 32'(d_ptch), 32'h0100);
`else
        cnt = 0;
        repeat (1100) begin
            @(negedge clk);
            if (bus.send_resp) cnt++;
        end
        check("hold ptch", 32'(d_ptch), 32'hFF38);
        check("hold roll", 32'(d_roll), 32'h1234);
        check("hold yaw", 32'(d_yaw), 32'h8000);
        check("hold thrst", 32'(thrst), 32'h005);
        check("hold silent", 32'(cnt), 32'h0);
`endif

        do_cmd("land", 8'h08, 16'hAAAA, 8'hA5);
        check("land ptch", 32'(d_ptch), 32'h0);
        check("land roll", 32'(d_roll), 32'h0);
        check("land yaw", 32'(d_yaw), 32'h0);
        check("land thrst", 32'(thrst), 32'h0);
        check("land motors_off", 32'(motors_off), 32'h0);
        do_cmd("off", 8'h09, 16'h0000, 8'hA5);
        check("off motors_off", 32'(motors_off), 32'h1);

        // Reset while calibrating abandons the calibration.
        do_cmd("pre_rst_ptch", 8'h02, 16'h0042, 8'hA5);
        start_cmd(8'h07, 16'h0000, 8'hA5, 1'b0);
        wait_accept("cal2");
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (strt_cal) found = 1'b1;
        end
        check("cal2 reached CAL", 32'(found), 32'h1);
        repeat (3) @(negedge clk);
        check("cal2 ical", 32'(inertial_cal), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst motors_off", 32'(motors_off), 32'h1);
        check("post_rst ical", 32'(inertial_cal), 32'h0);
        do_cmd("post_rst_batt", 8'h05, 16'h0000, 8'h37);
        check("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
